branch_predictor: RTL
=====================

# branch_predictor

Standalone, parametrised gshare direction predictor with an optional return-address stack (RAS), for use by the pipelined RV32I cores. Decode presents the current PC and instruction class and gets a same-cycle direction (and return target) prediction. Execute sends back the resolved outcome one cycle later to train the pattern table and the global history. A post-reset sweep FSM sets every counter to weakly-not-taken, so the table needs no per-entry reset.

## Interface
- `TABLE_BITS`, 9: log2 of pattern-table entries; index uses PC[TABLE_BITS+1:2].
- `HIST_BITS`, 6: global history length; legal range 1..TABLE_BITS.
- `RAS_DEPTH`, 4: return-stack entries; power of two, 2..16.
- `clk`  in  1: clock, all state updates on posedge.
- `resetn`  in  1: asynchronous active-low reset.
- `ready`  out  1: high once the init sweep is complete.
- `pd_valid`  in  1: decode slot holds a real instruction that advances this cycle (not stalled, not flushed).
- `pd_pc`  in  32: PC of the decode instruction.
- `pd_is_branch`  in  1: instruction is B-type.
- `pd_is_call`  in  1: JAL/JALR with rd=x1 or x5.
- `pd_is_ret`  in  1: JALR with rs1=x1/x5, rd≠rs1.
- `pd_taken`  out  1: predicted direction (counter MSB).
- `pd_index`  out  TABLE_BITS: table index used; carried down the pipe for update.
- `pd_ret_valid`  out  1: RAS holds a return target.
- `pd_ret_addr`  out  32: top-of-stack return target.
- `up_valid`  in  1: a B-type instruction resolved in execute this cycle.
- `up_index`  in  TABLE_BITS: index returned from `pd_index`.
- `up_taken`  in  1: actual branch outcome.

## Operation
- **Index**: `pd_pc[TABLE_BITS+1:2] XOR (hist << (TABLE_BITS-HIST_BITS))`. The read is combinational from the pattern table.
- **Counters**: 2-bit saturating. Taken increments to a maximum of 3; not-taken decrements to a minimum of 0.
- **Update**: when `up_valid` is high, write the saturated counter to `up_index` and set `hist <= {up_taken, hist[HIST_BITS-1:1]}`.
- **FSM states**: INIT and RUN.
  - INIT: an index counter writes 2'b01 to one entry per cycle, from 0 up to 2^TABLE_BITS-1, then moves to RUN.
  - During INIT: `ready`=0, `pd_taken`=0, `pd_ret_valid`=0, updates ignored, `hist` held at 0.
  - RUN is terminal until reset.
- **Reset values**: `ready`=0, `hist`=0, sweep counter=0, state=INIT, RAS count=0, RAS pointer=0, `pd_taken`=0, `pd_ret_valid`=0, `pd_ret_addr`=0.
- **Reset mid-sweep**: the sweep restarts from entry 0.
- **Same-index read and write**: if an update writes the index being predicted in the same cycle, the prediction uses the pre-update value. The new value is visible the next cycle.
- **Update and predict in the same cycle**: the prediction index uses the pre-shift `hist`.
- **RAS** (only when `pd_valid` and RUN):
  - Call pushes `pd_pc+4`.
  - Ret pops.
  - Call and ret together: pop then push, so only the top entry is replaced and the count is unchanged.
  - Push when full: the circular pointer overwrites the oldest entry and the count saturates at RAS_DEPTH.
  - Pop when empty: no change; `pd_ret_valid`=0.
  - `pd_ret_addr` is the entry at pointer-1 (mod RAS_DEPTH) and is 0 when empty.

## Timing
- Prediction: 0 cycles, combinational from `pd_pc`, `pd_is_*`, table, `hist`, RAS.
- Update: counter, history, and RAS changes take effect at the next posedge.
- Init: exactly 2^TABLE_BITS cycles after `resetn` rises. `ready` rises on the cycle after the last entry is written (512 cycles at default).
- No backpressure: the caller gates `pd_valid` and `up_valid` with its own stall and flush.

## Configuration
- `BP_RAS_EN`
  - Defined: RAS logic as above.
  - Undefined: no stack storage; `pd_ret_valid`=0 and `pd_ret_addr`=0 permanently; `pd_is_call` and `pd_is_ret` are ignored. The core then resolves all JALR in execute.

## Test plan
- **Reset/init**: assert `resetn`=0 for 3 cycles, release.
  - `ready`=0 for 512 cycles, then 1.
  - Every index then predicts not-taken (reads 2'b01).
  - Pulse `resetn` at sweep cycle 200: `ready` stays 0 for a full 512 cycles after release.
- **Saturation**: from RUN, issue 4 updates `up_taken`=1 at index 5 with history forced 0.
  - Counter goes 01→10→11→11; `pd_taken`=1 from after the first update.
  - 2 not-taken updates then give 01, so `pd_taken`=0.
- **History hashing**: 6 taken updates make `hist`=6'b111111.
  - `pd_pc`=0x0000_0010 (PC index 4) predicts index 4^(63<<3)=0x1FC.
- **Read/write collision**: counter at index 7 is 01; update taken at index 7 while predicting index 7 in the same cycle.
  - `pd_taken`=0 that cycle, 1 the next.
- **RAS overflow/underflow** (`BP_RAS_EN` defined): push calls at PCs 0x100, 0x200, 0x300, 0x400, 0x500.
  - 4 pops return 0x504, 0x404, 0x304, 0x204.
  - A 5th pop gives `pd_ret_valid`=0.
  - Call and ret together at PC 0x600 on stack [0x104] gives top 0x604, count 1.
- **Macro off**: same stimulus with `BP_RAS_EN` undefined: `pd_ret_valid` stays 0 throughout.

Source files
------------

// File: rtl/branch_predictor.sv
// gshare direction predictor with post-reset counter sweep and optional return-address stack.
// Define BP_RAS_EN to build the return-address stack; without it pd_ret_valid/pd_ret_addr are tied to 0.
module branch_predictor #(
    parameter int unsigned TABLE_BITS = 9,
    parameter int unsigned HIST_BITS  = 6,
    parameter int unsigned RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic                  ready,
    input  logic                  pd_valid,
    input  logic [31:0]           pd_pc,
    input  logic                  pd_is_branch,
    input  logic                  pd_is_call,
    input  logic                  pd_is_ret,
    output logic                  pd_taken,
    output logic [TABLE_BITS-1:0] pd_index,
    output logic                  pd_ret_valid,
    output logic [31:0]           pd_ret_addr,
    input  logic                  up_valid,
    input  logic [TABLE_BITS-1:0] up_index,
    input  logic                  up_taken
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                state_q;
    logic [TABLE_BITS-1:0] sweep_q;
    logic                  ready_q;
    logic [HIST_BITS-1:0]  hist_q, hist_d;
    logic [1:0]            pht [2**TABLE_BITS];
    logic [1:0]            ctr_cur, ctr_d;
    logic                  run;
    logic                  unused_inputs;

    assign run      = (state_q == S_RUN);
    assign ready    = ready_q;
    assign pd_index = pd_pc[TABLE_BITS+1:2] ^ (TABLE_BITS'(hist_q) << (TABLE_BITS - HIST_BITS));
    assign pd_taken = run & pht[pd_index][1];

    always_comb begin
        ctr_cur = pht[up_index];
        ctr_d   = ctr_cur;
        if (up_taken) begin
            if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'd1;
        end
    end

    // Shift through a widened vector so HIST_BITS=1 needs no special case.
    always_comb begin
        hist_d = hist_q;
        if (up_valid) hist_d = HIST_BITS'({up_taken, hist_q} >> 1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_INIT;
            sweep_q <= '0;
            ready_q <= 1'b0;
            hist_q  <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    sweep_q <= sweep_q + TABLE_BITS'(1);
                    if (sweep_q == '1) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN:   hist_q <= hist_d;
                default: state_q <= S_INIT;
            endcase
        end
    end

    // Table has no reset; the sweep initialises it before any prediction is trusted.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT)
            pht[sweep_q] <= 2'b01;
        else if (up_valid)
            pht[up_index] <= ctr_d;
    end

`ifdef BP_RAS_EN
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [31:0]   ras_q [RAS_DEPTH];
    logic [PW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] top;
    logic          push, pop;

    assign top  = ptr_q - PW'(1);
    assign push = pd_valid & run & pd_is_call;
    assign pop  = pd_valid & run & pd_is_ret & (cnt_q != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else if (push && pop) begin
            ras_q[top] <= pd_pc + 32'd4;
        end else if (push) begin
            ras_q[ptr_q] <= pd_pc + 32'd4;
            ptr_q        <= ptr_q + PW'(1);
            if (cnt_q != CW'(RAS_DEPTH)) cnt_q <= cnt_q + CW'(1);
        end else if (pop) begin
            ptr_q <= top;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign pd_ret_valid  = run & (cnt_q != '0);
    assign pd_ret_addr   = (cnt_q != '0) ? ras_q[top] : '0;
    assign unused_inputs = pd_is_branch;
`else
    assign pd_ret_valid  = 1'b0;
    assign pd_ret_addr   = '0;
    assign unused_inputs = ^{pd_is_branch, pd_valid, pd_is_call, pd_is_ret,
                             pd_pc[31:TABLE_BITS+2], pd_pc[1:0]};
`endif

endmodule
